// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_known_op = 1'b1;
      default:                                       is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           mem_timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           mem_timeout, state
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure state -> datapath strobe table; only the fetch strobes depend on mem_ready.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore strobe decode; every strobe not named in a state stays 0.
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state, memory wait watchdog.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned SW           = 4
) (
  input logic         clk,
  input logic         rst,
  mc_ctrl_fsm_if.master bus
);

  localparam int unsigned CW = (MEM_WAIT_MAX == 0) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_WAIT_MAX);

  state_t        state_q;
  logic [CW-1:0] wait_cnt;
  logic          timeout_q;
  logic          waiting;
  ctrl_t         ctrl;
  ctrl_t         ctrl_g;
  logic          illegal;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign illegal = (state_q == S_DECODE) && !is_known_op(bus.opcode);

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // State register, next-state selection and saturating wait counter with one-shot timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          unique case (bus.opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDIEX;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (bus.opcode == OP_LW)      state_q <= S_MEMRD;
          else if (bus.opcode == OP_SW) state_q <= S_MEMWR;
          else                          state_q <= S_FETCH;
        end
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state_q <= S_FETCH;
        S_EXEC:   state_q <= S_RWB;
        S_RWB:    state_q <= S_FETCH;
        S_BRANCH: state_q <= S_FETCH;
        S_JUMP:   state_q <= S_FETCH;
        S_ADDIEX: state_q <= S_ADDIWB;
        S_ADDIWB: state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase

      // Counter clears whenever the FSM is not stalled; at the limit it stops, so the pulse fires once.
      if (waiting && !bus.mem_ready) begin
        if (MEM_WAIT_MAX != 0 && wait_cnt != WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + CW'(1);
          if (wait_cnt == WAIT_LIMIT - CW'(1)) timeout_q <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Reset masks every output so an abandoned access cannot leak a strobe.
  always_comb begin
    ctrl_g = rst ? '0 : ctrl;
  end

  assign bus.IRWrite     = ctrl_g.ir_write;
  assign bus.PCWrite     = ctrl_g.pc_write;
  assign bus.PCWriteCond = ctrl_g.pc_write_cond;
  assign bus.IorD        = ctrl_g.iord;
  assign bus.MemRead     = ctrl_g.mem_read;
  assign bus.MemWrite    = ctrl_g.mem_write;
  assign bus.MemtoReg    = ctrl_g.mem_to_reg;
  assign bus.RegDst      = ctrl_g.reg_dst;
  assign bus.RegWrite    = ctrl_g.reg_write;
  assign bus.ALUSrcA     = ctrl_g.alu_src_a;
  assign bus.ALUSrcB     = ctrl_g.alu_src_b;
  assign bus.ALUOp       = ctrl_g.alu_op;
  assign bus.PCSource    = ctrl_g.pc_source;
  assign bus.illegal_op  = illegal && !rst;
  assign bus.mem_timeout = timeout_q && !rst;
  assign bus.state       = rst ? '0 : SW'(state_q);

endmodule
